// File: rtl/multicycle_decoder.sv
// ----------------------------------------------------------------------------
// multicycle_decoder
//   Sequential opcode decoder for the multicycle datapath. It accepts one
//   opcode per valid/ready handshake and steps it through DECODE, EXEC (one
//   cycle, or MUL_LAT cycles for MULT_OP) and WB. All outputs are registered.
//   flush_i aborts the in-flight opcode, and rst_i is an asynchronous reset.
//
//   Optional feature macro: DECODER_ILLEGAL_TRAP_EN
//     Defined   : if an opcode has any bit set above the ALU op field, it is
//                 retired from DECODE directly through WB with trap_o pulsed
//                 and no register write.
//     Undefined : there is no trap_o port, and every opcode is decoded
//                 normally.
// ----------------------------------------------------------------------------
module multicycle_decoder #(
  parameter int              OP_W    = 6,
  parameter int              ALUOP_W = 4,
  parameter logic [OP_W-1:0] MULT_OP = OP_W'(12),
  parameter int              MUL_LAT = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  output logic               instr_ready_o,
  input  logic               flush_i,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o,
  output logic               reg_dst_o,
  output logic               branch_o,
  output logic               reg_write_o,
  output logic               busy_o,
  output logic               done_o
`ifdef DECODER_ILLEGAL_TRAP_EN
  ,
  output logic               trap_o
`endif
);

  // The EXEC down-counter only needs to hold MUL_LAT-1.
  localparam int                CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t             state_q;
  logic [OP_W-1:0]    op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               busy_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               alu_src_q;
  logic               reg_dst_q;
  logic               branch_q;
  logic               reg_write_q;
  logic               done_q;

  // Decode fields derived from the latched opcode only. The live input bus is
  // ignored once the opcode has been accepted.
  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_branch;
  logic               dec_alu_src;
  logic               dec_reg_write;
  logic               dec_reg_dst;
  logic [CNT_W-1:0]   dec_cnt_init;

  assign dec_alu_op    = op_q[ALUOP_W-1:0];
  assign dec_branch    = op_q[2];
  assign dec_alu_src   = op_q[3];
  assign dec_reg_write = ~op_q[2];
  assign dec_reg_dst   = (op_q == '0);
  assign dec_cnt_init  = (op_q == MULT_OP) ? CNT_LOAD : '0;

`ifdef DECODER_ILLEGAL_TRAP_EN
  logic trap_q;
  logic dec_illegal;

  // The opcode is illegal if any bit above the ALU op field is set. If the
  // two fields are the same width, no opcode is illegal.
  if (ALUOP_W < OP_W) begin : g_illegal
    assign dec_illegal = |op_q[OP_W-1:ALUOP_W];
  end else begin : g_no_illegal
    assign dec_illegal = 1'b0;
  end

  assign trap_o = trap_q;
`endif

  // Single registered FSM. It holds the state, the latched opcode, the EXEC
  // counter and every output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments. Every register then
    // samples the pre-edge values, whatever the statement order.
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      branch_q    <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef DECODER_ILLEGAL_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else if (flush_i) begin
      // Abort: return to IDLE with every strobe and control cleared. In IDLE
      // this also blocks acceptance for this cycle.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_dst_q   <= 1'b0;
      branch_q    <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef DECODER_ILLEGAL_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid_i && ready_q) begin
            op_q    <= instr_op_i;
            state_q <= S_DECODE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_DECODE: begin
`ifdef DECODER_ILLEGAL_TRAP_EN
          if (dec_illegal) begin
            // Retire without execution. The controls stay at 0.
            state_q <= S_WB;
            done_q  <= 1'b1;
            trap_q  <= 1'b1;
          end else begin
`else
          begin
`endif
            state_q   <= S_EXEC;
            alu_op_q  <= dec_alu_op;
            alu_src_q <= dec_alu_src;
            reg_dst_q <= dec_reg_dst;
            cnt_q     <= dec_cnt_init;
            // With a single EXEC cycle, that first cycle is also the final
            // cycle, so the branch strobe starts here.
            branch_q  <= dec_branch && (dec_cnt_init == '0);
          end
        end

        S_EXEC: begin
          if (cnt_q == '0) begin
            state_q     <= S_WB;
            branch_q    <= 1'b0;
            reg_write_q <= dec_reg_write;
            done_q      <= 1'b1;
          end else begin
            cnt_q    <= cnt_q - 1'b1;
            // Raise the branch strobe on the edge into the final EXEC cycle.
            branch_q <= dec_branch && (cnt_q == CNT_W'(1));
          end
        end

        S_WB: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          alu_op_q    <= '0;
          alu_src_q   <= 1'b0;
          reg_dst_q   <= 1'b0;
          branch_q    <= 1'b0;
          reg_write_q <= 1'b0;
          done_q      <= 1'b0;
`ifdef DECODER_ILLEGAL_TRAP_EN
          trap_q      <= 1'b0;
`endif
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign busy_o        = busy_q;
  assign alu_op_o      = alu_op_q;
  assign alu_src_o     = alu_src_q;
  assign reg_dst_o     = reg_dst_q;
  assign branch_o      = branch_q;
  assign reg_write_o   = reg_write_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_multicycle_decoder.sv
// ----------------------------------------------------------------------------
// tb_multicycle_decoder
//   Self-checking bench for multicycle_decoder with default parameters.
//   A reference function gives the expected output vector for each cycle
//   after a handshake. It works from the opcode and from that cycle's offset
//   within the DECODE / EXEC / WB timeline.
// ----------------------------------------------------------------------------
module tb_multicycle_decoder;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 4;
  localparam int MUL_LAT = 3;
  localparam logic [OP_W-1:0] MULT_OP = 6'd12;

`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               instr_valid_i;
  logic [OP_W-1:0]    instr_op_i;
  logic               instr_ready_o;
  logic               flush_i;
  logic [ALUOP_W-1:0] alu_op_o;
  logic               alu_src_o;
  logic               reg_dst_o;
  logic               branch_o;
  logic               reg_write_o;
  logic               busy_o;
  logic               done_o;
  logic               trap_w;

  int total = 0;
  int bad   = 0;

  multicycle_decoder #(
    .OP_W(OP_W), .ALUOP_W(ALUOP_W), .MULT_OP(MULT_OP), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_op_i    (instr_op_i),
    .instr_ready_o (instr_ready_o),
    .flush_i       (flush_i),
    .alu_op_o      (alu_op_o),
    .alu_src_o     (alu_src_o),
    .reg_dst_o     (reg_dst_o),
    .branch_o      (branch_o),
    .reg_write_o   (reg_write_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef DECODER_ILLEGAL_TRAP_EN
    ,
    .trap_o        (trap_w)
`endif
  );

`ifndef DECODER_ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic               ready;
    logic               busy;
    logic               done;
    logic               rw;
    logic               br;
    logic               src;
    logic               dst;
    logic [ALUOP_W-1:0] alu;
    logic               trap;
  } obs_t;

  function automatic obs_t observe();
    obs_t o;
    o.ready = instr_ready_o; o.busy = busy_o; o.done = done_o;
    o.rw = reg_write_o; o.br = branch_o; o.src = alu_src_o;
    o.dst = reg_dst_o; o.alu = alu_op_o; o.trap = trap_w;
    return o;
  endfunction

  function automatic obs_t idle_vec();
    obs_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected outputs j cycles after the handshake edge: j=0 is DECODE,
  // 1..L is EXEC, L+1 is WB, and anything later is IDLE again.
  function automatic obs_t expect_at(logic [OP_W-1:0] op, int j);
    obs_t e = '0;
    int lat = (op == MULT_OP) ? MUL_LAT : 1;
    bit illegal = TRAP_EN && ((op >> ALUOP_W) != 0);
    if (illegal) begin
      if (j == 0)      begin e.busy = 1; end
      else if (j == 1) begin e.busy = 1; e.done = 1; e.trap = 1; end
      else             e = idle_vec();
    end else if (j == 0) begin
      e.busy = 1;
    end else if (j <= lat + 1) begin
      e.busy = 1;
      e.alu  = op % (1 << ALUOP_W);
      e.src  = op[3];
      e.dst  = (op == 0);
      e.br   = op[2] && (j == lat);
      e.rw   = (j == lat + 1) && !op[2];
      e.done = (j == lat + 1);
    end else begin
      e = idle_vec();
    end
    return e;
  endfunction

  // Called at a negedge while the DUT is idle. The task hands op over and
  // checks every cycle up to the return to IDLE. It aborts at cycle
  // flush_j if flush_j >= 0. While the DUT is busy, the bench drives noise
  // on the valid and opcode inputs.
  task automatic run_op(input logic [OP_W-1:0] op, input int flush_j, input string tag);
    obs_t o, e;
    int   lat  = (op == MULT_OP) ? MUL_LAT : 1;
    int   last = (TRAP_EN && ((op >> ALUOP_W) != 0)) ? 2 : lat + 2;
    instr_valid_i = 1'b1;
    instr_op_i    = op;
    @(posedge clk_i);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk_i);
      o = observe();
      e = expect_at(op, j);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s op=%0d cycle=%0d got=%h want=%h", tag, op, j, o, e);
      end
      if (j == flush_j) begin
        flush_i       = 1'b1;
        instr_valid_i = 1'b1;
        instr_op_i    = OP_W'($urandom);
        @(negedge clk_i);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        o = observe();
        total++;
        if (o !== idle_vec()) begin
          bad++;
          $display("FAIL %s_flush op=%0d got=%h want=%h", tag, op, o, idle_vec());
        end
        return;
      end
      instr_valid_i = (j < last - 1) ? 1'($urandom) : 1'b0;
      instr_op_i    = OP_W'($urandom);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_op_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    o = observe();
    total++;
    if (o !== idle_vec()) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", o, idle_vec());
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    run_op(6'd0,  -1, "rtype");
    run_op(6'd12, -1, "mult");
    run_op(6'd4,  -1, "branch");
    run_op(6'd8,  -1, "imm");
    run_op(6'h3F, -1, "illegal");
  endtask

  task automatic test_flush();
    // Flush in the middle EXEC cycle of MULT_OP, then accept a new opcode on
    // the first idle edge.
    run_op(MULT_OP, 2, "mult_flush");
    run_op(6'd5,   -1, "after_flush");
    run_op(6'd1,    0, "flush_decode");
    run_op(MULT_OP, 4, "flush_wb");
  endtask

  task automatic test_flush_idle();
    obs_t o;
    instr_valid_i = 1'b1; instr_op_i = 6'd0; flush_i = 1'b1;
    @(negedge clk_i);
    o = observe();
    total++;
    if (o !== idle_vec()) begin
      bad++;
      $display("FAIL flush_idle_block got=%h want=%h", o, idle_vec());
    end
    flush_i = 1'b0; instr_valid_i = 1'b0;
    run_op(6'd2, -1, "after_idle_flush");
  endtask

  task automatic test_back_to_back();
    logic [OP_W-1:0] op;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(3) == 0) ? MULT_OP : OP_W'($urandom);
      run_op(op, ($urandom_range(5) == 0) ? int'($urandom_range(MUL_LAT + 1)) : -1, "random");
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    instr_valid_i = 1'b1; instr_op_i = MULT_OP;
    @(posedge clk_i);
    instr_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);   // DECODE, EXEC1, EXEC2
    #1 rst_i = 1'b1;
    #1 o = observe();
    total++;
    if (o !== idle_vec()) begin
      bad++;
      $display("FAIL async_reset got=%h want=%h", o, idle_vec());
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    o = observe();
    total++;
    if (o !== idle_vec()) begin
      bad++;
      $display("FAIL after_reset_idle got=%h want=%h", o, idle_vec());
    end
    run_op(6'd0, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
